// File: rtl/load_store_unit.sv
// Load/store unit: validates a byte/halfword/word request, runs the read,
// read-modify-write or write cycle against a word-wide data memory, and returns a one-cycle response.
module load_store_unit #(
    parameter logic [31:0] MEM_BASE  = 32'h10010000,
    parameter logic [31:0] MEM_LIMIT = 32'h10010400
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic        mem_write,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_r;
    logic        ready_r;
    logic        store_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        fault_s;
    logic [31:0] aligned_s;

    function automatic logic req_faults(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr[0];
            SIZE_WORD: bad = (addr[1:0] != 2'b00);
            default:   bad = 1'b1;
        endcase
        if ((addr < MEM_BASE) || (addr >= MEM_LIMIT)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Little-endian lane pick followed by zero/sign extension; words pass through.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: result = uns ? {24'h000000, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = uns ? {16'h0000, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default:   result = word;
        endcase
        return result;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SIZE_BYTE: mask = 32'h000000FF << {lane, 3'b000};
            SIZE_HALF: mask = 32'h0000FFFF << {lane, 3'b000};
            default:   mask = 32'hFFFFFFFF;
        endcase
        data = wdata << {lane, 3'b000};
        return (word & ~mask) | (data & mask);
    endfunction

    // Request screening on the raw inputs, used only on the accept edge.
    always_comb begin
        fault_s   = req_faults(req_size, req_address);
        aligned_s = {req_address[31:2], 2'b00};
    end

    assign req_ready = ready_r;

    // Main sequencer with all outputs registered.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_r        <= IDLE;
            ready_r        <= 1'b1;
            store_r        <= 1'b0;
            size_r         <= 2'b00;
            unsigned_r     <= 1'b0;
            addr_r         <= 32'h00000000;
            wdata_r        <= 32'h00000000;
            resp_valid     <= 1'b0;
            resp_rdata     <= 32'h00000000;
            resp_fault     <= 1'b0;
            mem_address    <= 32'h00000000;
            mem_write      <= 1'b0;
            mem_write_data <= 32'h00000000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        ready_r    <= 1'b0;
                        store_r    <= req_store;
                        size_r     <= req_size;
                        unsigned_r <= req_unsigned;
                        addr_r     <= req_address;
                        wdata_r    <= req_wdata;
                        if (fault_s) begin
                            state_r    <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h00000000;
                        end else if (req_store && (req_size == SIZE_WORD)) begin
                            state_r        <= WRITE;
                            mem_address    <= aligned_s;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            state_r     <= READ;
                            mem_address <= aligned_s;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                READ: begin
                    // Sub-word stores reuse the read word; loads finish here.
                    if (store_r) begin
                        state_r        <= WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= store_merge(mem_read_data, wdata_r, size_r, addr_r[1:0]);
                    end else begin
                        state_r     <= RESP;
                        mem_address <= 32'h00000000;
                        resp_valid  <= 1'b1;
                        resp_fault  <= 1'b0;
                        resp_rdata  <= load_extract(mem_read_data, size_r, addr_r[1:0], unsigned_r);
                    end
                end
                WRITE: begin
                    state_r        <= RESP;
                    mem_address    <= 32'h00000000;
                    mem_write      <= 1'b0;
                    mem_write_data <= 32'h00000000;
                    resp_valid     <= 1'b1;
                    resp_fault     <= 1'b0;
                    resp_rdata     <= 32'h00000000;
                end
                RESP: begin
                    state_r    <= IDLE;
                    ready_r    <= 1'b1;
                    resp_valid <= 1'b0;
                end
                default: begin
                    state_r        <= IDLE;
                    ready_r        <= 1'b1;
                    resp_valid     <= 1'b0;
                    mem_address    <= 32'h00000000;
                    mem_write      <= 1'b0;
                    mem_write_data <= 32'h00000000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a falling-edge-commit word memory model.
module tb_load_store_unit;

    logic        clock;
    logic        clear_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];
    int total;
    int bad;

    load_store_unit dut (
        .clock(clock), .clear_n(clear_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_address(mem_address), .mem_write(mem_write),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        if ((mem_address >= 32'h10010000) && (mem_address < 32'h10010400))
            mem_read_data = mem[mem_address[9:2]];
        else
            mem_read_data = 32'hDEADBEEF;
    end

    always @(negedge clock) begin
        if (mem_write && (mem_address >= 32'h10010000) && (mem_address < 32'h10010400))
            mem[mem_address[9:2]] <= mem_write_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        store;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] wr_data;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic st, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] wd, input logic f,
                                input logic [31:0] rd, input int l, input logic [31:0] wr);
        vec_t v;
        v.store = st; v.size = sz; v.uns = u; v.addr = a; v.wdata = wd;
        v.fault = f; v.rdata = rd; v.lat = l; v.wr_data = wr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        int writes;
        logic [31:0] wd;
        logic [31:0] rd;
        logic flt;
        lat = 0; writes = 0; wd = 32'h0; rd = 32'h0; flt = 1'b0;
        @(negedge clock);
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        req_store = v.store; req_size = v.size; req_unsigned = v.uns;
        req_address = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 6 && lat == 0; n++) begin
            @(negedge clock);
            if (mem_write) begin
                writes++;
                wd = mem_write_data;
            end
            if (resp_valid) begin
                lat = n;
                rd = resp_rdata;
                flt = resp_fault;
            end
        end
        check({tag, ".latency"}, lat, v.lat);
        check({tag, ".fault"}, {31'h0, flt}, {31'h0, v.fault});
        check({tag, ".rdata"}, rd, v.rdata);
        check({tag, ".writes"}, writes, (v.store && !v.fault) ? 1 : 0);
        if (v.store && !v.fault) check({tag, ".wdata"}, wd, v.wr_data);
        @(negedge clock);
        check({tag, ".pulse"}, {31'h0, resp_valid}, 32'h0);
        check({tag, ".hold"}, resp_rdata, v.rdata);
        check({tag, ".idle_wr"}, {31'h0, mem_write}, 32'h0);
    endtask

    initial begin
        logic saw_wr;
        logic saw_resp;
        logic [5:0] rv_seq;
        logic [5:0] rdy_seq;
        logic [31:0] rd1;
        logic [31:0] rd2;
        total = 0; bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 32'h00000064;
        mem[1] = 32'd200;
        mem[2] = 32'h80017F80;
        mem[255] = 32'h12345678;

        vecs[0]  = mk(1'b0, 2'b10, 1'b0, 32'h10010004, 32'h0,        1'b0, 32'h000000C8, 2, 32'h0);
        vecs[1]  = mk(1'b1, 2'b00, 1'b0, 32'h10010001, 32'h000000AB, 1'b0, 32'h0,        3, 32'h0000AB64);
        vecs[2]  = mk(1'b0, 2'b00, 1'b1, 32'h10010001, 32'h0,        1'b0, 32'h000000AB, 2, 32'h0);
        vecs[3]  = mk(1'b0, 2'b00, 1'b0, 32'h10010001, 32'h0,        1'b0, 32'hFFFFFFAB, 2, 32'h0);
        vecs[4]  = mk(1'b0, 2'b01, 1'b0, 32'h10010003, 32'h0,        1'b1, 32'h0,        1, 32'h0);
        vecs[5]  = mk(1'b1, 2'b10, 1'b0, 32'h10010400, 32'h55555555, 1'b1, 32'h0,        1, 32'h0);
        vecs[6]  = mk(1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'h0,        1'b1, 32'h0,        1, 32'h0);
        vecs[7]  = mk(1'b0, 2'b01, 1'b0, 32'h1001000A, 32'h0,        1'b0, 32'hFFFF8001, 2, 32'h0);
        vecs[8]  = mk(1'b0, 2'b01, 1'b0, 32'h10010008, 32'h0,        1'b0, 32'h00007F80, 2, 32'h0);
        vecs[9]  = mk(1'b1, 2'b01, 1'b0, 32'h10010002, 32'h1234CAFE, 1'b0, 32'h0,        3, 32'hCAFEAB64);
        vecs[10] = mk(1'b0, 2'b10, 1'b0, 32'h10010000, 32'h0,        1'b0, 32'hCAFEAB64, 2, 32'h0);
        vecs[11] = mk(1'b1, 2'b10, 1'b0, 32'h100103FC, 32'hA5A50F0F, 1'b0, 32'h0,        2, 32'hA5A50F0F);
        vecs[12] = mk(1'b0, 2'b10, 1'b0, 32'h100103FC, 32'h0,        1'b0, 32'hA5A50F0F, 2, 32'h0);
        vecs[13] = mk(1'b0, 2'b11, 1'b0, 32'h10010000, 32'h0,        1'b1, 32'h0,        1, 32'h0);
        vecs[14] = mk(1'b1, 2'b10, 1'b0, 32'h10010002, 32'h77777777, 1'b1, 32'h0,        1, 32'h0);
        vecs[15] = mk(1'b0, 2'b00, 1'b0, 32'h10010003, 32'h0,        1'b0, 32'hFFFFFFCA, 2, 32'h0);
        vecs[16] = mk(1'b0, 2'b01, 1'b1, 32'h1001000A, 32'h0,        1'b0, 32'h00008001, 2, 32'h0);

        clear_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_address = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clock);
        check("rst.ready", {31'h0, req_ready}, 32'h1);
        check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst.resp_fault", {31'h0, resp_fault}, 32'h0);
        check("rst.resp_rdata", resp_rdata, 32'h0);
        check("rst.mem_address", mem_address, 32'h0);
        check("rst.mem_write", {31'h0, mem_write}, 32'h0);
        check("rst.mem_write_data", mem_write_data, 32'h0);
        clear_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset during the READ cycle of a halfword store.
        @(negedge clock);
        req_store = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
        req_address = 32'h10010002; req_wdata = 32'h00001111; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        check("abort.read_addr", mem_address, 32'h10010000);
        clear_n = 1'b0;
        #1;
        check("abort.mem_address", mem_address, 32'h0);
        check("abort.ready", {31'h0, req_ready}, 32'h1);
        @(negedge clock);
        clear_n = 1'b1;
        saw_wr = 1'b0; saw_resp = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            if (mem_write) saw_wr = 1'b1;
            if (resp_valid) saw_resp = 1'b1;
        end
        check("abort.no_write", {31'h0, saw_wr}, 32'h0);
        check("abort.no_resp", {31'h0, saw_resp}, 32'h0);
        check("abort.mem_intact", mem[0], 32'hCAFEAB64);
        run_vec("after_abort", vecs[10]);

        // Back-to-back loads with req_valid held high.
        @(negedge clock);
        req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_address = 32'h10010004; req_valid = 1'b1;
        @(posedge clock);
        #1 req_address = 32'h10010008;
        rv_seq = 6'b0; rdy_seq = 6'b0; rd1 = 32'h0; rd2 = 32'h0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clock);
            rv_seq[n-1] = resp_valid;
            rdy_seq[n-1] = req_ready;
            if (n == 2) rd1 = resp_rdata;
            if (n == 5) begin
                rd2 = resp_rdata;
                req_valid = 1'b0;
            end
        end
        check("b2b.resp_valid_seq", {26'h0, rv_seq}, {26'h0, 6'b010010});
        check("b2b.ready_seq", {26'h0, rdy_seq}, {26'h0, 6'b100100});
        check("b2b.rdata1", rd1, 32'h000000C8);
        check("b2b.rdata2", rd2, 32'h80017F80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BASE, default 32'h10010000, meaning the first valid data-memory byte address.
REQ-002 SHALL have parameter MEM_LIMIT, default 32'h10010400, meaning the first invalid byte address above MEM_BASE.
REQ-003 SHALL have port clock  in  1  system clock; one clock, with all state updating on the rising edge.
REQ-004 SHALL have port clear_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request.
REQ-007 SHALL have port req_store  in  1  1=store, 0=load.
REQ-008 SHALL have port req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  in  1  loads zero-extend when 1 and sign-extend when 0.
REQ-010 SHALL have port req_address  in  32  byte address.
REQ-011 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-012 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-013 SHALL have port resp_rdata  out  32  extended load data.
REQ-014 SHALL have port resp_fault  out  1  request rejected.
REQ-015 SHALL have port mem_address  out  32  word-aligned address to data memory.
REQ-016 SHALL have port mem_write  out  1  memory write enable; memory commits it on the falling clock edge.
REQ-017 SHALL have port mem_write_data  out  32  full word to write.
REQ-018 SHALL have port mem_read_data  in  32  combinational read word from memory.

Function
REQ-019 SHALL implement the FSM states IDLE, READ, WRITE and RESP, with req_ready=1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge in IDLE with req_valid=1, register all req_* fields, and ignore the inputs in every other state.
REQ-021 SHALL fault a request on any of: size 11; halfword with addr[0]=1; word with addr[1:0]!=0; address <MEM_BASE or >=MEM_LIMIT.
REQ-022 SHALL handle a faulting request as IDLE->RESP with no memory cycle, resp_fault=1 and resp_rdata=0.
REQ-023 SHALL sequence loads as IDLE->READ->RESP, capturing mem_read_data at the end of READ, for a latency of 2 cycles from the accept edge to resp_valid.
REQ-024 SHALL sequence word stores as IDLE->WRITE->RESP, with mem_write=1 and mem_write_data=req_wdata during WRITE, for a latency of 2 cycles.
REQ-025 SHALL sequence byte and halfword stores as IDLE->READ->WRITE->RESP, for a latency of 3 cycles.
REQ-026 SHALL form the sub-word store write word as the READ word with only the addressed lanes replaced, in little-endian order: byte lane = addr[1:0], halfword lane = addr[1].
REQ-027 SHALL select the load lane by the same little-endian rule, then extend it to 32 bits according to req_unsigned; a word load is passed through unchanged.
REQ-028 SHALL drive mem_address={addr[31:2],2'b00} in READ and WRITE, and 0 otherwise.
REQ-029 SHALL assert mem_write only in WRITE, for exactly one cycle per store, and SHALL drive mem_write_data=0 outside WRITE.
REQ-030 SHALL hold resp_valid high for exactly one cycle, in RESP, with no backpressure, and SHALL return to IDLE after RESP.
REQ-031 SHALL hold resp_rdata and resp_fault stable from RESP until the next RESP, and SHALL return resp_rdata=0 for stores.
REQ-032 SHALL NOT accept a new request in the RESP cycle, so the minimum request spacing is (latency+1) cycles.

Reset
REQ-033 SHALL, while clear_n=0, force state=IDLE and resp_valid=0, resp_rdata=0, resp_fault=0, mem_address=0, mem_write=0, mem_write_data=0, with req_ready=1.
REQ-034 SHALL, when clear_n falls mid-operation, abort the operation immediately with no further mem_write pulse and no resp_valid, and SHALL accept a request on the first rising edge after clear_n returns high.

Verification
REQ-035 SHALL verify a word load: memory word 0x10010004=200, lw 0x10010004 accepted at edge T -> resp_valid at T+2, resp_rdata=0x000000C8, resp_fault=0.
REQ-036 SHALL verify a byte store followed by loads: word 0x10010000=0x00000064, sb 0x10010001 with data 0x000000AB -> READ then WRITE cycle with mem_write_data=0x0000AB64, resp at T+3; then lbu 0x10010001 -> 0x000000AB and lb 0x10010001 -> 0xFFFFFFAB.
REQ-037 SHALL verify faults: lh 0x10010003 -> resp at T+1 with resp_fault=1, resp_rdata=0 and mem_write never high; sw 0x10010400 and lw 0x1000FFFC -> resp_fault=1.
REQ-038 SHALL verify reset mid-operation: clear_n pulsed low during the READ cycle of sh 0x10010002 -> no mem_write and no resp_valid, req_ready=1, and the next lw completes normally.
REQ-039 SHALL verify back-to-back requests: req_valid held high for two lw requests -> second accepted at T+3 (after RESP), responses at T+2 and T+5.
